// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with 3-sample majority vote,
//            optional even/odd parity and stop-bit checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            tick_q, tick_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [1:0]            smp_q, smp_d;
  logic                  maj_q, maj_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic [5:0]            w_half;
  logic                  w_last;
  logic                  w_maj;

  assign w_half = presc_q >> 1;
  assign w_last = (tick_q == presc_q - 6'd1);
  // Third vote is the live line value at tick P/2+1
  assign w_maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    bit_d     = bit_q;
    smp_d     = smp_q;
    maj_d     = maj_q;
    perr_d    = perr_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;

    if (state_q != S_IDLE) begin
      tick_d = w_last ? 6'd0 : tick_q + 6'd1;
      if (tick_q == w_half - 6'd1) smp_d[0] = RX_IN;
      if (tick_q == w_half)        smp_d[1] = RX_IN;
      if (tick_q == w_half + 6'd1) maj_d    = w_maj;
    end

    case (state_q)
      S_IDLE: begin
        tick_d = 6'd0;
        if (!RX_IN) begin
          state_d   = S_START;
          tick_d    = 6'd1;
          presc_d   = PRESCALE;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_d     = '0;
          perr_d    = 1'b0;
        end
      end
      S_START: begin
        if ((tick_q == w_half + 6'd1) && w_maj) begin
          state_d = S_IDLE;
          tick_d  = 6'd0;
        end else if (w_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = maj_q;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_last) begin
          perr_d  = maj_q ^ (^shift_q) ^ par_typ_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_last) begin
          state_d   = S_IDLE;
          valid_d   = maj_q & ~perr_q;
          par_err_d = perr_q;
          stp_err_d = ~maj_q;
          if (maj_q && !perr_q) pdata_d = shift_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      bit_q     <= '0;
      smp_q     <= '0;
      maj_q     <= 1'b0;
      perr_q    <= 1'b0;
      shift_q   <= '0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      maj_q     <= maj_d;
      perr_q    <= perr_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Frame-level reference model bench for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       cyc;
    bit       dv;
    bit       pe;
    bit       se;
    bit [7:0] d;
  } exp_t;

  exp_t     expq[$];
  int       cyc = 0;
  int       n_tests = 0;
  int       n_fail = 0;
  bit [7:0] last_good = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outcome of each frame is derived from the bits put on the line.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        check_eq("missed_strobe_cycle", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        if (e.dv) last_good = e.d;
        check_eq("data_valid", DATA_VALID, e.dv);
        check_eq("par_err",    PAR_ERR,    e.pe);
        check_eq("stp_err",    STP_ERR,    e.se);
        check_eq("p_data",     P_DATA,     last_good);
      end else begin
        if (DATA_VALID || PAR_ERR || STP_ERR)
          check_eq("spurious_strobe", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);
        if (P_DATA !== last_good)
          check_eq("p_data_hold", P_DATA, last_good);
      end
      if (!RST) last_good = 8'h00;
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  function automatic logic [5:0] rand_p();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Entered and left at posedge+1; cycle 0 of the frame is the entry cycle.
  task automatic send_frame(input bit [7:0] d, input int p, input bit pe, input bit pt,
                            input bit par_bad, input bit stop_bit, input bit vote_glitch,
                            input bit scramble, input int rst_at);
    bit   bits[$];
    exp_t e;
    int   k;
    bit   v;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ par_bad);
    bits.push_back(stop_bit);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    if (rst_at < 0) begin
      e.cyc = cyc + 1 + p * bits.size();
      e.pe  = pe & par_bad;
      e.se  = ~stop_bit;
      e.dv  = stop_bit & ~(pe & par_bad);
      e.d   = d;
      expq.push_back(e);
    end
    k = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < p; j++) begin
        v = bits[b];
        if (vote_glitch && b >= 1 && b <= 8 && j == p / 2 - 1) v = ~v;
        RX_IN = v;
        if (scramble && k == 2) begin
          PRESCALE = rand_p();
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
        if (k == rst_at) RST = 1'b0;
        @(posedge CLK); #1;
        if (k == rst_at) begin
          RST   = 1'b1;
          RX_IN = 1'b1;
          @(negedge CLK);
          check_eq("rst_p_data",  P_DATA, 8'h00);
          check_eq("rst_strobes", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);
          @(posedge CLK); #1;
          return;
        end
        k++;
      end
    end
  endtask

  initial begin
    int gap;
    bit pe;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_p_data",     P_DATA,     8'h00);
    check_eq("reset_data_valid", DATA_VALID, 1'b0);
    check_eq("reset_par_err",    PAR_ERR,    1'b0);
    check_eq("reset_stp_err",    STP_ERR,    1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(4);

    // 1: P=8 even parity, good frame
    send_frame(8'h75, 8, 1, 0, 0, 1, 0, 0, -1);
    idle(3);
    // 2: P=16 odd parity, good then wrong parity
    send_frame(8'hE5, 16, 1, 1, 0, 1, 0, 0, -1);
    idle(2);
    send_frame(8'h75, 16, 1, 1, 1, 1, 0, 0, -1);
    idle(2);
    // 3: P=32 no parity, back-to-back
    send_frame(8'h46, 32, 0, 0, 0, 1, 0, 0, -1);
    send_frame(8'hA3, 32, 0, 0, 0, 1, 0, 0, -1);
    // 4: stop bit 0, then line high, then a good frame
    send_frame(8'h55, 8, 0, 0, 0, 0, 0, 0, -1);
    idle(20);
    send_frame(8'h9A, 8, 0, 0, 0, 1, 0, 0, -1);
    // break: line stays low across frames, each ends in a stop error
    send_frame(8'h00, 8, 0, 0, 0, 0, 0, 0, -1);
    send_frame(8'h00, 8, 0, 0, 0, 0, 0, 0, -1);
    idle(5);
    // 5: 2-cycle glitch, next start exactly at P/2+2
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    idle(4);
    send_frame(8'hC3, 8, 0, 0, 0, 1, 0, 0, -1);
    idle(3);

    for (int n = 0; n < 40; n++) begin
      pe  = 1'($urandom);
      send_frame(8'($urandom), int'(rand_p()), pe, 1'($urandom),
                 pe && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0,
                 1'($urandom), 1'($urandom), -1);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end
    idle(3);
    send_frame(8'h11, 8, 0, 0, 0, 1, 0, 0, -1);
    idle(3);

    // 6: reset at cycle 40 of a P=8 frame, then a clean frame
    send_frame(8'hF0, 8, 1, 0, 0, 1, 0, 0, 40);
    idle(10);
    send_frame(8'h3C, 8, 0, 0, 0, 1, 0, 0, -1);
    idle(6);

    check_eq("pending_expectations", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart of the system's UART transmitter, using the same frame format and parity configuration.
- Oversamples `RX_IN` by a programmable prescale, majority-votes three mid-bit samples, and deserialises LSB-first data.
- Checks optional parity and the stop bit.
- Presents a parallel word with a one-cycle valid strobe to the system register/FIFO side.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame.

Ports:
- `CLK` in, 1: receiver clock, running at PRESCALE × baud rate.
- `RST` in, 1: synchronous reset, active-low.
- `RX_IN` in, 1: serial line, idle high. Already synchronised to `CLK` upstream.
- `PRESCALE` in, 6: oversampling ratio. Legal values are 8, 16 and 32; any other value is undefined.
- `PAR_EN` in, 1: 1 means a parity bit follows the data.
- `PAR_TYP` in, 1: 0 = even parity, 1 = odd parity.
- `P_DATA` out, DATA_WIDTH: last correctly received word.
- `DATA_VALID` out, 1: one-cycle strobe; `P_DATA` is new.
- `PAR_ERR` out, 1: one-cycle strobe; parity mismatch in the frame just ended.
- `STP_ERR` out, 1: one-cycle strobe; stop bit sampled 0.

## Operation
Frame format: start bit (0), `DATA_WIDTH` data bits LSB-first, optional parity bit, stop bit (1).

Configuration latch:
- `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched on the start-detect cycle.
- Changes to them mid-frame are ignored.

Counters:
- The tick counter counts 0..P-1 within each bit; P is the latched prescale.
- The bit counter indexes the data bits.

Sampling:
- `RX_IN` is sampled at ticks P/2-1, P/2 and P/2+1 of each bit.
- The bit value is the majority of the three samples (2 of 3).

FSM states:
- IDLE:
  - Tick counter is 0.
  - When `RX_IN` = 0, go to START; the detect cycle is tick 0 of the start bit.
- START:
  - At tick P/2+1, if the majority is 1 (a glitch), return to IDLE on the next cycle and drop the frame silently.
  - Otherwise, at tick P-1, go to DATA.
- DATA:
  - At tick P-1, shift the majority bit into the shift register, LSB first.
  - After bit `DATA_WIDTH`-1, go to PARITY if `PAR_EN`=1, else go to STOP.
- PARITY:
  - Expected bit is XOR(data) for even parity, ~XOR(data) for odd parity.
  - At tick P-1, record a mismatch flag and go to STOP.
- STOP:
  - At tick P-1, go to IDLE.
  - Strobe outputs on the following cycle:
    - `DATA_VALID`=1 and `P_DATA` loaded only if the stop bit = 1 and there is no parity mismatch.
    - `PAR_ERR`=1 on a parity mismatch.
    - `STP_ERR`=1 if the stop majority is 0.
    - Both error strobes may assert together.

Error frames:
- On an error frame, `P_DATA` keeps its previous value.

Line held low (break):
- IDLE re-detects a start immediately after the stop-error frame.
- Each such frame ends in STP_ERR; there is no special break handling.

Back-to-back frames:
- A start bit that falls low on the cycle the FSM re-enters IDLE is detected at that cycle, with zero idle gap.

Reset:
- With `RST`=0 at a rising edge, the FSM goes to IDLE and all counters and the shift register clear.
- Outputs after reset: `P_DATA`=0, `DATA_VALID`=0, `PAR_ERR`=0, `STP_ERR`=0.
- Reset mid-frame discards the partial frame with no strobe.

## Timing
- Cycle 0 is the start-detect cycle.
- Frame length N = P × (1 + DATA_WIDTH + PAR_EN + 1) cycles.
- STOP tick P-1 falls on cycle N-1.
- The strobes and `P_DATA` update are visible during cycle N, i.e. registered off the edge ending cycle N-1.
- Each strobe is high for exactly one cycle and is never asserted outside cycle N of a frame.
- Glitch reject: the FSM is in IDLE at cycle P/2+2.
- Sample points sit at 50% ±1 tick of each bit; receiver tolerance is about ±(P/2-2)/P of a bit over a full frame.

## Test plan
1. P=8, PAR_EN=1, PAR_TYP=0. Send 0x75 with parity bit 1 and stop bit 1. Expect `P_DATA`=0x75 and `DATA_VALID` high at cycle 88 only; `PAR_ERR`=`STP_ERR`=0.
2. P=16, PAR_EN=1, PAR_TYP=1. Send 0xE5 with parity bit 0. Expect `DATA_VALID` at cycle 176 with `P_DATA`=0xE5. Then send 0x75 with parity bit 1 (wrong). Expect `PAR_ERR` at that frame's cycle 176, no `DATA_VALID`, and `P_DATA` still 0xE5.
3. P=32, PAR_EN=0. Send 0x46 immediately followed, with no gap, by 0xA3. Expect `DATA_VALID` at cycles 320 and 640, with `P_DATA` 0x46 then 0xA3.
4. P=8, PAR_EN=0. Send 0x55 with stop bit 0, then hold the line high. Expect `STP_ERR` at cycle 80, `DATA_VALID`=0, and the FSM back in IDLE.
5. P=8. Drive a 2-cycle low glitch on `RX_IN` at cycles 0-1. Expect no strobes and the FSM in IDLE by cycle 6. A valid frame that follows is received correctly.
6. Drop `RST` at cycle 40 of a P=8 frame for one cycle. Expect all outputs at 0 and no strobe from the partial frame. A subsequent frame with 0x3C yields `P_DATA`=0x3C and a single `DATA_VALID`.
